// File: rtl/irq_pending_ctrl.sv
// Interrupt pending stage: synchronizes raw lines, detects edges or follows levels,
// keeps per-line pending/overflow state and drives the masked vector to the arbiter.
module irq_pending_ctrl #(
   parameter  int NUM_INT_PORTS = 8,
   parameter  int SYNC_STAGES   = 2,
   localparam int ID_W          = $clog2(NUM_INT_PORTS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_INT_PORTS-1:0] IRQ_RAW,
   input  logic [NUM_INT_PORTS-1:0] IRQ_EDGE,
   input  logic [NUM_INT_PORTS-1:0] IRQ_MASK,
   input  logic                     ACK_VLD,
   input  logic [ID_W-1:0]          ACK_ID,
   input  logic                     OVF_CLR,
   output logic [NUM_INT_PORTS-1:0] IRQ,
   output logic [NUM_INT_PORTS-1:0] PEND,
   output logic [NUM_INT_PORTS-1:0] OVF
);

   logic [SYNC_STAGES-1:0][NUM_INT_PORTS-1:0] sync_q;
   logic [NUM_INT_PORTS-1:0] sync_s;
   logic [NUM_INT_PORTS-1:0] hist_q;
   logic [NUM_INT_PORTS-1:0] edge_q;
   logic [NUM_INT_PORTS-1:0] pend_q;
   logic [NUM_INT_PORTS-1:0] ovf_q;
   logic [NUM_INT_PORTS-1:0] rise;
   logic [NUM_INT_PORTS-1:0] mode_chg;
   logic [NUM_INT_PORTS-1:0] ack_hit;
   logic [NUM_INT_PORTS-1:0] pend_d;
   logic [NUM_INT_PORTS-1:0] ovf_d;
   logic [ID_W:0]            ack_ext;
   logic                     ack_ok;

   assign sync_s   = sync_q[SYNC_STAGES-1];
   assign rise     = sync_s & ~hist_q;
   assign mode_chg = edge_q ^ IRQ_EDGE;
   assign ack_ext  = {1'b0, ACK_ID};
   assign ack_ok   = ACK_VLD && (ack_ext < (ID_W+1)'(NUM_INT_PORTS));

   always_comb begin
      ack_hit = '0;
      pend_d  = '0;
      ovf_d   = '0;
      for (int i = 0; i < NUM_INT_PORTS; i++) begin
         ack_hit[i] = ack_ok && (ACK_ID == ID_W'(i));
         if (mode_chg[i]) begin
            // mode switch flushes the line; the new mode takes effect a cycle later
            pend_d[i] = 1'b0;
            ovf_d[i]  = 1'b0;
         end else if (edge_q[i]) begin
            pend_d[i] = rise[i] | (pend_q[i] & ~ack_hit[i]);
            ovf_d[i]  = (ovf_q[i] & ~OVF_CLR) | (rise[i] & pend_q[i] & ~ack_hit[i]);
         end else begin
            pend_d[i] = sync_s[i];
            ovf_d[i]  = ovf_q[i] & ~OVF_CLR;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= '0;
         hist_q <= '0;
         edge_q <= '0;
         pend_q <= '0;
         ovf_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], IRQ_RAW};
         hist_q <= sync_s;
         edge_q <= IRQ_EDGE;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   assign PEND = pend_q;
   assign OVF  = ovf_q;
   assign IRQ  = pend_q & ~IRQ_MASK;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: an 8-line instance for the main scenarios
// and a 6-line instance for the out-of-range acknowledge case.
module tb_irq_pending_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] raw, edge_m, mask, irq, pend, ovf;
   logic       ack_vld, ovf_clr;
   logic [2:0] ack_id;
   logic [5:0] raw6, edge6, mask6, irq6, pend6, ovf6;
   logic       ack_vld6, ovf_clr6;
   logic [2:0] ack_id6;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   irq_pending_ctrl #(.NUM_INT_PORTS(8), .SYNC_STAGES(2)) u_dut (
      .CLK(clk), .RST(rst), .IRQ_RAW(raw), .IRQ_EDGE(edge_m), .IRQ_MASK(mask),
      .ACK_VLD(ack_vld), .ACK_ID(ack_id), .OVF_CLR(ovf_clr),
      .IRQ(irq), .PEND(pend), .OVF(ovf)
   );

   irq_pending_ctrl #(.NUM_INT_PORTS(6), .SYNC_STAGES(2)) u_dut6 (
      .CLK(clk), .RST(rst), .IRQ_RAW(raw6), .IRQ_EDGE(edge6), .IRQ_MASK(mask6),
      .ACK_VLD(ack_vld6), .ACK_ID(ack_id6), .OVF_CLR(ovf_clr6),
      .IRQ(irq6), .PEND(pend6), .OVF(ovf6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      raw = '0; edge_m = 8'hDF; mask = '0;
      ack_vld = 1'b0; ack_id = '0; ovf_clr = 1'b0;
      raw6 = '0; edge6 = 6'h3F; mask6 = '0;
      ack_vld6 = 1'b0; ack_id6 = '0; ovf_clr6 = 1'b0;

      // reset state
      #1;
      check("rst_pend", 32'(pend), 32'h00);
      check("rst_ovf",  32'(ovf),  32'h00);
      check("rst_irq",  32'(irq),  32'h00);
      cyc(2);
      rst = 1'b0;
      cyc(3);

      // edge capture on line 3
      raw[3] = 1'b1;
      cyc(1); check("edge_lat_k",  32'(pend), 32'h00);
      cyc(1); check("edge_lat_k1", 32'(pend), 32'h00);
      raw[3] = 1'b0;
      cyc(1); check("edge_pend", 32'(pend), 32'h08);
      check("edge_irq", 32'(irq), 32'h08);
      ack_vld = 1'b1; ack_id = 3'd3;
      cyc(1); check("edge_ack", 32'(pend), 32'h00);
      ack_vld = 1'b0;

      // level mode on line 5
      raw[5] = 1'b1;
      cyc(2); check("lvl_lag", 32'(irq), 32'h00);
      for (int i = 0; i < 10; i++) begin
         ack_vld = (i == 4); ack_id = 3'd5;
         cyc(1); check("lvl_hold", 32'(irq), 32'h20);
      end
      ack_vld = 1'b0;
      raw[5] = 1'b0;
      cyc(2); check("lvl_fall_lag", 32'(irq), 32'h20);
      cyc(1); check("lvl_fall", 32'(irq), 32'h00);
      check("lvl_ovf", 32'(ovf), 32'h00);

      // line 1: rise coincident with ack, overflow, OVF_CLR
      raw[1] = 1'b1;
      cyc(3); check("sim_first", 32'(pend), 32'h02);
      raw[1] = 1'b0;
      cyc(3);
      raw[1] = 1'b1;
      cyc(2);
      ack_vld = 1'b1; ack_id = 3'd1;
      cyc(1);
      ack_vld = 1'b0;
      check("sim_set_wins", 32'(pend), 32'h02);
      check("sim_no_ovf",   32'(ovf),  32'h00);
      raw[1] = 1'b0;
      cyc(3);
      raw[1] = 1'b1;
      cyc(3); check("ovf_set", 32'(ovf), 32'h02);
      check("ovf_pend", 32'(pend), 32'h02);
      raw[1] = 1'b0; ovf_clr = 1'b1;
      cyc(1); ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf), 32'h00);
      cyc(2);
      raw[1] = 1'b1;
      cyc(2);
      ovf_clr = 1'b1;
      cyc(1); ovf_clr = 1'b0;
      check("ovf_set_wins", 32'(ovf), 32'h02);
      raw[1] = 1'b0; ovf_clr = 1'b1;
      cyc(1); ovf_clr = 1'b0;
      check("ovf_clr2", 32'(ovf), 32'h00);
      ack_vld = 1'b1; ack_id = 3'd1;
      cyc(1); ack_vld = 1'b0;
      check("sim_ack", 32'(pend), 32'h00);

      // masking on line 0
      mask = 8'h01; raw[0] = 1'b1;
      cyc(2); raw[0] = 1'b0;
      cyc(1); check("mask_pend", 32'(pend), 32'h01);
      check("mask_irq", 32'(irq), 32'h00);
      mask = 8'h00;
      #1; check("unmask_irq", 32'(irq), 32'h01);
      ack_vld = 1'b1; ack_id = 3'd0;
      cyc(1); ack_vld = 1'b0;
      check("mask_ack", 32'(pend), 32'h00);

      // stray ack to a non-pending line
      raw[3] = 1'b1;
      cyc(2); raw[3] = 1'b0;
      cyc(1); check("stray_setup", 32'(pend), 32'h08);
      ack_vld = 1'b1; ack_id = 3'd2;
      cyc(1);
      check("stray_pend", 32'(pend), 32'h08);
      check("stray_irq",  32'(irq),  32'h08);
      check("stray_ovf",  32'(ovf),  32'h00);
      ack_id = 3'd3;
      cyc(1); ack_vld = 1'b0;
      check("stray_clean", 32'(pend), 32'h00);

      // out-of-range ack on the 6-line instance
      raw6 = 6'h20;
      cyc(2); raw6 = '0;
      cyc(1); check("n6_pend", 32'(pend6), 32'h20);
      ack_vld6 = 1'b1; ack_id6 = 3'd7;
      cyc(1);
      check("n6_oor_pend", 32'(pend6), 32'h20);
      check("n6_oor_irq",  32'(irq6),  32'h20);
      ack_id6 = 3'd5;
      cyc(1); ack_vld6 = 1'b0;
      check("n6_ack", 32'(pend6), 32'h00);

      // build PEND=0xFF, OVF=0x10, then reset mid-operation
      raw = 8'hFF;
      cyc(3); check("all_pend", 32'(pend), 32'hFF);
      check("all_ovf", 32'(ovf), 32'h00);
      raw = 8'h20;
      cyc(3);
      raw = 8'h30;
      cyc(3); check("pre_rst_ovf", 32'(ovf), 32'h10);
      check("pre_rst_pend", 32'(pend), 32'hFF);
      #2; rst = 1'b1;
      #1;
      check("mid_rst_pend", 32'(pend), 32'h00);
      check("mid_rst_ovf",  32'(ovf),  32'h00);
      check("mid_rst_irq",  32'(irq),  32'h00);
      raw = 8'h10;
      cyc(1);
      rst = 1'b0;
      cyc(2); check("rel_lag", 32'(pend), 32'h00);
      cyc(1); check("rel_rise", 32'(pend), 32'h10);
      cyc(10);
      check("rel_once_pend", 32'(pend), 32'h10);
      check("rel_once_ovf",  32'(ovf),  32'h00);
      ack_vld = 1'b1; ack_id = 3'd4;
      cyc(1); ack_vld = 1'b0;
      cyc(5); check("rel_no_repeat", 32'(pend), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Upstream conditioning stage for the interrupt arbiter. Takes raw asynchronous interrupt lines and synchronizes them.
- Per line, either detects rising edges or follows the level, then latches pending state and applies masking.
- Drives the arbiter's IRQ vector.
- The consumer returns the serviced ID on an acknowledge strobe, which clears edge-mode pending bits.

Parameters:
NUM_INT_PORTS, 8, number of interrupt lines (>=2)
SYNC_STAGES, 2, synchronizer depth per line (>=2)

Ports:
CLK  input  1  single clock
RST  input  1  asynchronous, active-high reset
IRQ_RAW  input  NUM_INT_PORTS  raw asynchronous interrupt sources
IRQ_EDGE  input  NUM_INT_PORTS  per-line mode: 1=rising-edge, 0=level
IRQ_MASK  input  NUM_INT_PORTS  per-line mask: 1=suppress IRQ output
ACK_VLD  input  1  acknowledge strobe from consumer (one cycle)
ACK_ID  input  clog2(NUM_INT_PORTS)  ID being acknowledged
OVF_CLR  input  1  clears all OVF bits
IRQ  output  NUM_INT_PORTS  masked pending vector to arbiter
PEND  output  NUM_INT_PORTS  unmasked pending status
OVF  output  NUM_INT_PORTS  sticky: edge lost because line already pending

Behaviour:
- Reset (async assert, sync release):
  - all synchronizer flops, edge-history flop, registered mode copy, PEND, OVF and IRQ = 0.
  - Mid-operation reset clears everything immediately.
  - After release, an edge-mode line held high produces exactly one rise event, because history resets to 0.
- Synchronizer: SYNC_STAGES flops per line. s = last stage. h = s delayed one cycle. rise = s & ~h.
- Edge mode (registered IRQ_EDGE[i]=1):
  - PEND[i] sets on rise[i].
  - PEND[i] clears on ACK_VLD with ACK_ID==i.
  - Rise and matching ack in the same cycle: PEND stays 1 (set wins). No OVF.
  - Rise while PEND[i]=1 and no matching ack that cycle: OVF[i] set; PEND stays 1.
- Level mode (IRQ_EDGE[i]=0):
  - PEND[i] <= s[i] every cycle.
  - ACK has no effect; the source must deassert.
  - OVF is never set.
- Ack rules:
  - ACK_ID >= NUM_INT_PORTS: ignored.
  - Ack to a non-pending line: ignored, no error.
  - Only one ID per cycle.
- Mode change: IRQ_EDGE is registered. If the registered value differs from the input in a cycle, PEND[i] and OVF[i] clear next cycle and the new mode applies from the following cycle.
- Masking:
  - IRQ = PEND & ~IRQ_MASK, combinational from registered PEND.
  - A masked line still latches pending; unmasking later exposes it immediately.
- OVF_CLR: clears all OVF next edge. A new overflow in the same cycle wins (bit stays 1).
- Latency: IRQ_RAW rising before posedge k → PEND/IRQ high after posedge k+SYNC_STAGES. Ack at posedge m → PEND low after posedge m.
- Widths: clog2 as in the arbiter package. Only the low clog2 bits of ACK_ID are compared; the range check is against NUM_INT_PORTS.
- Glitches shorter than one CLK period may be missed. This is accepted; sources must hold for >= 2 cycles.

Test Plan:
- Edge capture: N=8, line 3 edge mode, pulse IRQ_RAW[3] for 2 cycles at posedge k → PEND=0x08 and IRQ=0x08 after posedge k+2. Ack ID 3 → PEND=0x00 next cycle.
- Level mode: line 5 level, raw held high 10 cycles → IRQ[5]=1 throughout, with 2-cycle lag. ACK_ID=5 causes no change. Raw low → IRQ[5]=0 two cycles later.
- Simultaneous set/ack and overflow:
  - line 1 rise coincident with ACK_ID=1 → PEND[1] stays 1, OVF=0.
  - Second rise while pending, no ack → OVF=0x02.
  - OVF_CLR → OVF=0x00.
- Mask: line 0 masked, edge arrives → PEND=0x01, IRQ=0x00. Unmask → IRQ=0x01 same cycle.
- Invalid/stray ack: ACK_ID=2 with PEND[2]=0 → no change to any output. Ack with an out-of-range ID (non-power-of-2 N=6, ID 7) → ignored.
- Reset mid-operation: PEND=0xFF, OVF=0x10, assert RST between edges → all outputs 0 immediately. Release with raw[4] high in edge mode → PEND=0x10 exactly once, no repeat.
